// File: rtl/window_feeder_if.sv
// Handshake/bus bundle between a pixel source, the window feeder and the window consumer.
interface window_feeder_if #(
  parameter int unsigned PIXEL_WIDTH = 30,
  parameter int unsigned IMG_W       = 32,
  parameter int unsigned IMG_H       = 32
);
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [PIXEL_WIDTH-1:0] in_pixel;
  logic                   shift_en;
  logic                   shift_dir;
  logic [PIXEL_WIDTH-1:0] pixel_out;
  logic                   window_valid;
  logic                   win_ack;
  logic [COL_W-1:0]       win_col;
  logic [ROW_W-1:0]       win_row;
  logic                   frame_done;

  // Feeder side
  modport slave (
    input  start, in_valid, in_pixel, win_ack,
    output in_ready, shift_en, shift_dir, pixel_out, window_valid,
           win_col, win_row, frame_done
  );

  // Source / consumer side
  modport master (
    output start, in_valid, in_pixel, win_ack,
    input  in_ready, shift_en, shift_dir, pixel_out, window_valid,
           win_col, win_row, frame_done
  );
endinterface

// File: rtl/window_feeder.sv
// Sliding-window feeder: streams column-band-ordered pixels into a shift-register
// window array, fills the first window of each band top-to-bottom, then slides one
// column at a time, presenting each settled window until the consumer acknowledges.
module window_feeder #(
  parameter int unsigned PIXEL_WIDTH = 30,
  parameter int unsigned WINDOW_W    = 9,
  parameter int unsigned WINDOW_H    = 9,
  parameter int unsigned IMG_W       = 32,
  parameter int unsigned IMG_H       = 32
) (
  input  logic          clock,
  input  logic          reset,
  window_feeder_if.slave bus
);
  localparam int unsigned FILL_N   = WINDOW_W * WINDOW_H;
  localparam int unsigned CNT_W    = $clog2(FILL_N + 1);
  localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LAST_COL = IMG_W - WINDOW_W;
  localparam int unsigned LAST_ROW = IMG_H - WINDOW_H;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SLIDE,
    S_SETTLE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       shift_cnt_q, shift_cnt_d;
  logic [COL_W-1:0]       win_col_q, win_col_d;
  logic [ROW_W-1:0]       win_row_q, win_row_d;
  logic                   in_ready_q, in_ready_d;
  logic                   shift_en_q, shift_en_d;
  logic                   shift_dir_q, shift_dir_d;
  logic [PIXEL_WIDTH-1:0] pixel_out_q, pixel_out_d;
  logic                   window_valid_q, window_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   accept_c;

  // Next-state, counters and registered-output intent
  always_comb begin
    state_d        = state_q;
    shift_cnt_d    = shift_cnt_q;
    win_col_d      = win_col_q;
    win_row_d      = win_row_q;
    shift_dir_d    = shift_dir_q;
    pixel_out_d    = pixel_out_q;
    accept_c       = bus.in_valid & ((state_q == S_FILL) | (state_q == S_SLIDE));
    shift_en_d     = accept_c;

    if (accept_c) begin
      pixel_out_d = bus.in_pixel;
      shift_dir_d = (state_q == S_SLIDE);
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_FILL;
          shift_cnt_d = '0;
          win_col_d   = '0;
          win_row_d   = '0;
        end
      end
      S_FILL: begin
        if (accept_c) begin
          if (shift_cnt_q == CNT_W'(FILL_N - 1)) begin
            shift_cnt_d = '0;
            state_d     = S_SETTLE;
          end else begin
            shift_cnt_d = shift_cnt_q + CNT_W'(1);
          end
        end
      end
      S_SLIDE: begin
        if (accept_c) begin
          if (shift_cnt_q == CNT_W'(WINDOW_H - 1)) begin
            shift_cnt_d = '0;
            state_d     = S_SETTLE;
          end else begin
            shift_cnt_d = shift_cnt_q + CNT_W'(1);
          end
        end
      end
      S_SETTLE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.win_ack) begin
          shift_cnt_d = '0;
          if (win_col_q < COL_W'(LAST_COL)) begin
            win_col_d = win_col_q + COL_W'(1);
            state_d   = S_SLIDE;
          end else if (win_row_q < ROW_W'(LAST_ROW)) begin
            win_col_d = '0;
            win_row_d = win_row_q + ROW_W'(1);
            state_d   = S_FILL;
          end else begin
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d     = (state_d == S_FILL) | (state_d == S_SLIDE);
    window_valid_d = (state_d == S_HOLD);
    frame_done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      shift_cnt_q    <= '0;
      win_col_q      <= '0;
      win_row_q      <= '0;
      in_ready_q     <= 1'b0;
      shift_en_q     <= 1'b0;
      shift_dir_q    <= 1'b0;
      pixel_out_q    <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_cnt_q    <= shift_cnt_d;
      win_col_q      <= win_col_d;
      win_row_q      <= win_row_d;
      in_ready_q     <= in_ready_d;
      shift_en_q     <= shift_en_d;
      shift_dir_q    <= shift_dir_d;
      pixel_out_q    <= pixel_out_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.shift_en     = shift_en_q;
  assign bus.shift_dir    = shift_dir_q;
  assign bus.pixel_out    = pixel_out_q;
  assign bus.window_valid = window_valid_q;
  assign bus.win_col      = win_col_q;
  assign bus.win_row      = win_row_q;
  assign bus.frame_done   = frame_done_q;
endmodule

// File: doc/window_feeder.md
WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 Parameter PIXEL_WIDTH, default 30, sets the pixel bit width.
REQ-002 Parameter WINDOW_W, default 9, sets the window width in pixels (columns).
REQ-003 Parameter WINDOW_H, default 9, sets the window height in pixels (rows).
REQ-004 Parameter IMG_W, default 32, sets the image width; IMG_W SHALL be >= WINDOW_W.
REQ-005 Parameter IMG_H, default 32, sets the image height; IMG_H SHALL be >= WINDOW_H.
REQ-006 Port clock, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-low reset (reset==0 resets state).
REQ-008 Port start, input, 1 bit: single-cycle frame start request.
REQ-009 Port in_valid, input, 1 bit: in_pixel is valid.
REQ-010 Port in_ready, output, 1 bit: the feeder accepts a pixel this cycle.
REQ-011 Port in_pixel, input, PIXEL_WIDTH bits: pixel data, in column-band order.
REQ-012 Port shift_en, output, 1 bit: shift strobe to the window array.
REQ-013 Port shift_dir, output, 1 bit: 0 = top-to-bottom (fill); 1 = left-to-right (new column).
REQ-014 Port pixel_out, output, PIXEL_WIDTH bits: pixel injected into the window edge.
REQ-015 Port window_valid, output, 1 bit: the window holds a complete, settled window.
REQ-016 Port win_ack, input, 1 bit: consumer has taken the current window.
REQ-017 Port win_col, output, clog2(IMG_W) bits: left column of the current window.
REQ-018 Port win_row, output, clog2(IMG_H) bits: top row of the current window.
REQ-019 Port frame_done, output, 1 bit: one-cycle pulse after the last window of a frame is acknowledged.

Function
REQ-020 The FSM SHALL have the states IDLE, FILL, SLIDE, SETTLE, HOLD and DONE.
REQ-021 IDLE->FILL SHALL occur when start==1; this transition SHALL clear shift_cnt, win_col and win_row.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 in_ready SHALL be 1 only in FILL and SLIDE, and accept SHALL = in_valid & in_ready.
REQ-024 An accept in cycle t SHALL produce shift_en=1, with pixel_out = the accepted pixel, in cycle t+1 (registered); shift_en SHALL be 0 in all other cycles.
REQ-025 shift_dir SHALL be registered alongside shift_en: 0 for FILL accepts, 1 for SLIDE accepts.
REQ-026 FILL SHALL accept exactly WINDOW_W*WINDOW_H pixels and then go to SETTLE.
REQ-027 SLIDE SHALL accept exactly WINDOW_H pixels and then go to SETTLE.
REQ-028 SETTLE SHALL last exactly one cycle and then go to HOLD.
REQ-029 In HOLD, window_valid SHALL be 1; window_valid SHALL rise 2 cycles after the last accept of a window.
REQ-030 HOLD SHALL remain until win_ack==1; win_ack outside HOLD SHALL be ignored.
REQ-031 On win_ack in HOLD, the next state SHALL be:
  - if win_col < IMG_W-WINDOW_W: win_col += 1, go to SLIDE;
  - else if win_row < IMG_H-WINDOW_H: win_col = 0, win_row += 1, go to FILL;
  - else go to DONE.
REQ-032 DONE SHALL assert frame_done for exactly one cycle, then go to IDLE.
REQ-033 shift_cnt SHALL count accepts within the current FILL/SLIDE phase and SHALL clear on every entry to FILL or SLIDE.
REQ-034 The per-frame accept count SHALL be (IMG_H-WINDOW_H+1) * (WINDOW_W*WINDOW_H + (IMG_W-WINDOW_W)*WINDOW_H).
REQ-035 When in_valid=0 in FILL/SLIDE, counters SHALL hold and shift_en SHALL be 0 (stall).
REQ-036 When IMG_W==WINDOW_W, no SLIDE phase SHALL occur; each band SHALL be FILL then HOLD only.

Reset
REQ-037 When reset==0 at a rising edge, the state SHALL become IDLE, counters SHALL be 0, and in_ready, shift_en, shift_dir, pixel_out, window_valid, win_col, win_row and frame_done SHALL all be 0.
REQ-038 A reset in any state, including mid-FILL or HOLD, SHALL abandon the frame; no shift_en SHALL follow the reset edge.

Verification
REQ-039 Params IMG=10x10, WINDOW=9x9; start, in_valid held 1, win_ack held 1 -> 180 shift_en pulses; 4 windows with (col,row) = (0,0),(1,0),(0,1),(1,1); frame_done once.
REQ-040 Fill timing: last FILL accept at cycle t -> shift_en at t+1, window_valid=1 from t+2, in_ready=0 from t+1.
REQ-041 win_ack held 0 for 20 cycles in HOLD -> window_valid stays 1, in_ready stays 0, no shift_en; ack -> SLIDE with shift_dir=1 for 9 accepts.
REQ-042 in_valid toggled 1/0 during FILL -> exactly 81 shift_en pulses, pixel_out sequence equals input sequence, no drops or duplicates.
REQ-043 reset=0 for one cycle mid-SLIDE -> all outputs 0 next cycle; a new start begins at (0,0) with FILL.
REQ-044 start pulsed during FILL or HOLD -> ignored; counts and window positions match REQ-039.
